// File: rtl/uart_rx_unescape_pkg.sv
// uart_rx_unescape_pkg: framing byte defaults shared with the transmit-side escaper,
// plus the receiver state encoding.
package uart_rx_unescape_pkg;
   localparam logic [7:0] FLAG_BYTE_DEF = 8'h7E;
   localparam logic [7:0] ESC_BYTE_DEF  = 8'h7D;
   localparam logic [7:0] ESC_XOR_DEF   = 8'h20;
   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_e;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: rxd synchronizer and 8N1 bit-level receiver; strobes are combinational
// in the stop-sample cycle so the top-level register adds exactly one cycle.
module uart_rx_core
   import uart_rx_unescape_pkg::*;
#(
   parameter int BIT_CYCLES = 50
) (
   input  logic       mclk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] byte_data,
   output logic       byte_strobe,
   output logic       frame_err
);
   localparam int CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);
   logic [1:0]    sync_q;
   logic          rxs_prev_q;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          rxs, expired;
   assign rxs       = sync_q[1];
   assign expired   = cnt_q == '0;
   assign byte_data = shift_q;
   always_ff @(posedge mclk or posedge reset)
      if (reset) begin
         sync_q     <= 2'b11;
         rxs_prev_q <= 1'b1;
         state_q    <= RX_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
      end else begin
         sync_q     <= {sync_q[0], rxd};
         rxs_prev_q <= rxs;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
      end
   always_comb begin
      state_d     = state_q;
      cnt_d       = expired ? cnt_q : cnt_q - 1'b1;
      bit_d       = bit_q;
      shift_d     = shift_q;
      byte_strobe = 1'b0;
      frame_err   = 1'b0;
      case (state_q)
         RX_IDLE:
            if (rxs_prev_q && !rxs) begin
               state_d = RX_START;
               cnt_d   = HALF_LOAD;
            end
         RX_START:
            if (expired) begin
               state_d = rxs ? RX_IDLE : RX_DATA;
               cnt_d   = FULL_LOAD;
               bit_d   = '0;
            end
         RX_DATA:
            if (expired) begin
               shift_d = {rxs, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               cnt_d   = FULL_LOAD;
               state_d = bit_q == 3'd7 ? RX_STOP : RX_DATA;
            end
         RX_STOP:
            // Leaving for IDLE in the sample cycle lets a back-to-back start edge be seen.
            if (expired) begin
               byte_strobe = rxs;
               frame_err   = !rxs;
               state_d     = rxs ? RX_IDLE : RX_BREAK;
            end
         RX_BREAK:
            if (rxs) state_d = RX_IDLE;
         default:
            state_d = RX_IDLE;
      endcase
   end
endmodule

// File: rtl/uart_rx_unescape.sv
// uart_rx_unescape: UART receive front end that strips flag bytes and escape
// sequences, emitting registered single-cycle data/flag/error strobes.
module uart_rx_unescape
   import uart_rx_unescape_pkg::*;
#(
   parameter int         BIT_CYCLES = 50,
   parameter logic [7:0] FLAG_BYTE  = FLAG_BYTE_DEF,
   parameter logic [7:0] ESC_BYTE   = ESC_BYTE_DEF,
   parameter logic [7:0] ESC_XOR    = ESC_XOR_DEF
) (
   input  logic       mclk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_data_strobe,
   output logic       rx_flag,
   output logic       rx_error
);
   logic [7:0] byte_data;
   logic       byte_strobe, frame_err;
   logic       esc_q, esc_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       strobe_q, strobe_d, flag_q, flag_d, error_q, error_d;
   uart_rx_core #(.BIT_CYCLES(BIT_CYCLES)) u_core (
      .mclk        (mclk),
      .reset       (reset),
      .rxd         (rxd),
      .byte_data   (byte_data),
      .byte_strobe (byte_strobe),
      .frame_err   (frame_err)
   );
   assign rx_data        = rx_data_q;
   assign rx_data_strobe = strobe_q;
   assign rx_flag        = flag_q;
   assign rx_error       = error_q;
   always_ff @(posedge mclk or posedge reset)
      if (reset) begin
         esc_q     <= 1'b0;
         rx_data_q <= 8'h00;
         strobe_q  <= 1'b0;
         flag_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         esc_q     <= esc_d;
         rx_data_q <= rx_data_d;
         strobe_q  <= strobe_d;
         flag_q    <= flag_d;
         error_q   <= error_d;
      end
   always_comb begin
      esc_d     = esc_q;
      rx_data_d = rx_data_q;
      strobe_d  = 1'b0;
      flag_d    = 1'b0;
      error_d   = 1'b0;
      if (frame_err) begin
         error_d = 1'b1;
         esc_d   = 1'b0;
      end else if (byte_strobe) begin
         // A flag always wins, silently dropping a half-finished escape.
         if (byte_data == FLAG_BYTE) begin
            flag_d = 1'b1;
            esc_d  = 1'b0;
         end else if (esc_q) begin
            rx_data_d = byte_data ^ ESC_XOR;
            strobe_d  = 1'b1;
            esc_d     = 1'b0;
         end else if (byte_data == ESC_BYTE) begin
            esc_d = 1'b1;
         end else begin
            rx_data_d = byte_data;
            strobe_d  = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_unescape.sv
// tb_uart_rx_unescape: drives serial frames onto rxd and checks the decoded event
// stream against a queue-based unescaping model.
module tb_uart_rx_unescape;
   localparam int B   = 50;
   localparam int LAT = 2 + B / 2 + 9 * B + 1;
   localparam logic [1:0] K_DATA = 2'd1, K_FLAG = 2'd2, K_ERR = 2'd3;
   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
   } ev_t;
   logic       mclk = 1'b0, reset = 1'b1, rxd = 1'b1;
   logic [7:0] rx_data;
   logic       rx_data_strobe, rx_flag, rx_error;
   int         nvec = 0, nfail = 0, cyc = 0;
   ev_t        ev_q[$], exp_q[$];
   int         ev_cyc[$], t_q[$];
   logic [7:0] bq[$];
   logic [7:0] last_data = 8'h00;

   uart_rx_unescape #(.BIT_CYCLES(B)) dut (
      .mclk           (mclk),
      .reset          (reset),
      .rxd            (rxd),
      .rx_data        (rx_data),
      .rx_data_strobe (rx_data_strobe),
      .rx_flag        (rx_flag),
      .rx_error       (rx_error)
   );

   always #5 mclk = ~mclk;
   always @(posedge mclk) cyc <= cyc + 1;

   initial forever begin
      @(negedge mclk);
      if (reset) last_data = 8'h00;
      else begin
         int n;
         n = int'(rx_data_strobe) + int'(rx_flag) + int'(rx_error);
         if (rx_data_strobe) begin
            ev_q.push_back({K_DATA, rx_data});
            ev_cyc.push_back(cyc);
            last_data = rx_data;
         end else begin
            nvec++;
            if (rx_data !== last_data) begin
               nfail++;
               if (nfail < 40) $display("FAIL hold: rx_data=%h required %h", rx_data, last_data);
            end
         end
         if (rx_flag) begin ev_q.push_back({K_FLAG, 8'h00}); ev_cyc.push_back(cyc); end
         if (rx_error) begin ev_q.push_back({K_ERR, 8'h00}); ev_cyc.push_back(cyc); end
         if (n > 0) begin
            nvec++;
            if (n > 1) begin
               nfail++;
               $display("FAIL exclusive: %0d strobes high, required 1", n);
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge mclk);
   endtask

   task automatic send(input logic [7:0] b, input int stop_bits = 1, input logic stop_val = 1'b1,
                       input int gap = 4);
      t_q.push_back(cyc);
      rxd = 1'b0;
      wait_cyc(B);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         wait_cyc(B);
      end
      rxd = stop_val;
      wait_cyc(stop_bits * B);
      rxd = 1'b1;
      wait_cyc(gap);
   endtask

   // Expected events for a clean byte stream, straight from the unescaping rules.
   task automatic model();
      logic esc = 1'b0;
      exp_q.delete();
      foreach (bq[i]) begin
         if (bq[i] == 8'h7E) begin exp_q.push_back({K_FLAG, 8'h00}); esc = 1'b0; end
         else if (esc) begin exp_q.push_back({K_DATA, bq[i] ^ 8'h20}); esc = 1'b0; end
         else if (bq[i] == 8'h7D) esc = 1'b1;
         else exp_q.push_back({K_DATA, bq[i]});
      end
   endtask

   task automatic clear();
      ev_q.delete();
      ev_cyc.delete();
      t_q.delete();
   endtask

   task automatic send_bq(input int gap);
      model();
      foreach (bq[i]) send(bq[i], 1, 1'b1, gap);
      wait_cyc(5);
   endtask

   task automatic test_reset();
      wait_cyc(3);
      nvec += 4;
      if (rx_data !== 8'h00) begin nfail++; $display("FAIL reset rx_data: %h required 00", rx_data); end
      if (rx_data_strobe !== 1'b0) begin nfail++; $display("FAIL reset strobe: %b required 0", rx_data_strobe); end
      if (rx_flag !== 1'b0) begin nfail++; $display("FAIL reset flag: %b required 0", rx_flag); end
      if (rx_error !== 1'b0) begin nfail++; $display("FAIL reset error: %b required 0", rx_error); end
      reset = 1'b0;
      wait_cyc(4);
   endtask

   task automatic test_plain();
      clear();
      bq = '{8'h41, 8'h00};
      send_bq(B);
      nvec++;
      if (ev_q.size() != exp_q.size()) begin nfail++; $display("FAIL plain count: %0d events, required %0d", ev_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
         nvec += 2;
         if (ev_q[i] !== exp_q[i]) begin nfail++; $display("FAIL plain ev%0d: %h required %h", i, ev_q[i], exp_q[i]); end
         if (ev_cyc[i] - t_q[i] != LAT) begin nfail++; $display("FAIL plain latency%0d: %0d required %0d", i, ev_cyc[i] - t_q[i], LAT); end
      end
   endtask

   task automatic test_escape();
      clear();
      bq = '{8'h7E, 8'h7D, 8'h5E, 8'h7D, 8'h5D, 8'h55};
      send_bq(B);
      nvec++;
      if (ev_q.size() != 4) begin nfail++; $display("FAIL escape count: %0d events, required 4", ev_q.size()); end
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
         nvec++;
         if (ev_q[i] !== exp_q[i]) begin nfail++; $display("FAIL escape ev%0d: %h required %h", i, ev_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_abort();
      clear();
      bq = '{8'h7D, 8'h7E, 8'h12};
      send_bq(B);
      nvec++;
      if (ev_q.size() != 2) begin nfail++; $display("FAIL abort count: %0d events, required 2", ev_q.size()); end
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
         nvec++;
         if (ev_q[i] !== exp_q[i]) begin nfail++; $display("FAIL abort ev%0d: %h required %h", i, ev_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_framing();
      clear();
      exp_q = '{'{K_ERR, 8'h00}, '{K_DATA, 8'h33}};
      send(8'hFF, 3, 1'b0, B);
      send(8'h33);
      wait_cyc(5);
      nvec++;
      if (ev_q.size() != exp_q.size()) begin nfail++; $display("FAIL framing count: %0d events, required %0d", ev_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
         nvec++;
         if (ev_q[i] !== exp_q[i]) begin nfail++; $display("FAIL framing ev%0d: %h required %h", i, ev_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_glitch();
      clear();
      rxd = 1'b0;
      wait_cyc(10);
      rxd = 1'b1;
      wait_cyc(2 * B);
      nvec++;
      if (ev_q.size() != 0) begin nfail++; $display("FAIL glitch events: %0d, required 0", ev_q.size()); end
      bq = '{8'h5A};
      send_bq(B);
      nvec++;
      if (ev_q.size() != 1 || ev_q[0] !== exp_q[0]) begin nfail++; $display("FAIL glitch recover: %0d events, required 1 of %h", ev_q.size(), exp_q[0]); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] p = 8'hC3;
      clear();
      rxd = 1'b0;
      wait_cyc(B);
      for (int i = 0; i < 4; i++) begin
         rxd = p[i];
         wait_cyc(B);
      end
      rxd = p[4];
      wait_cyc(B / 2);
      reset = 1'b1;
      wait_cyc(1);
      nvec += 4;
      if (rx_data !== 8'h00) begin nfail++; $display("FAIL midreset rx_data: %h required 00", rx_data); end
      if (rx_data_strobe !== 1'b0) begin nfail++; $display("FAIL midreset strobe: %b required 0", rx_data_strobe); end
      if (rx_flag !== 1'b0) begin nfail++; $display("FAIL midreset flag: %b required 0", rx_flag); end
      if (rx_error !== 1'b0) begin nfail++; $display("FAIL midreset error: %b required 0", rx_error); end
      rxd = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(2 * B);
      nvec++;
      if (ev_q.size() != 0) begin nfail++; $display("FAIL midreset partial: %0d events, required 0", ev_q.size()); end
      bq = '{8'hA5};
      send_bq(B);
      nvec++;
      if (ev_q.size() != 1 || ev_q[0] !== exp_q[0]) begin nfail++; $display("FAIL midreset A5: %0d events, required 1 of %h", ev_q.size(), exp_q[0]); end
   endtask

   task automatic test_back_to_back();
      clear();
      bq = '{8'h11, 8'h22, 8'h33};
      send_bq(0);
      nvec++;
      if (ev_q.size() != 3) begin nfail++; $display("FAIL b2b count: %0d events, required 3", ev_q.size()); end
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
         nvec += 2;
         if (ev_q[i] !== exp_q[i]) begin nfail++; $display("FAIL b2b ev%0d: %h required %h", i, ev_q[i], exp_q[i]); end
         if (ev_cyc[i] - t_q[i] != LAT) begin nfail++; $display("FAIL b2b latency%0d: %0d required %0d", i, ev_cyc[i] - t_q[i], LAT); end
      end
   endtask

   task automatic test_random();
      clear();
      bq.delete();
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0: bq.push_back(8'h7E);
            1, 2: bq.push_back(8'h7D);
            3: bq.push_back(8'h5D);
            default: bq.push_back(8'($urandom()));
         endcase
      end
      model();
      foreach (bq[i]) send(bq[i], 1, 1'b1, int'($urandom_range(0, B)));
      wait_cyc(5);
      nvec++;
      if (ev_q.size() != exp_q.size()) begin nfail++; $display("FAIL random count: %0d events, required %0d", ev_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
         nvec++;
         if (ev_q[i] !== exp_q[i]) begin nfail++; $display("FAIL random ev%0d: %h required %h", i, ev_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_plain();
      test_escape();
      test_abort();
      test_framing();
      test_glitch();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
